// File: rtl/mem_req_scheduler.sv
// Round-robin arbiter of I$ refill, D$ load and store-buffer requests onto one memory channel, with load/store credits.
// gnt_o is same-cycle, mem_req_o follows one cycle later; a request waiting for mem_gnt_i blocks new grants.
module mem_req_scheduler #(
  parameter int AddrWidth            = 64,
  parameter int DataWidth            = 64,
  parameter int MaxOutstandingLoads  = 2,
  parameter int MaxOutstandingStores = 7
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [2:0]                      req_i,
  output logic [2:0]                      gnt_o,
  input  logic [2:0][AddrWidth-1:0]       addr_i,
  input  logic                            nc_i,
  input  logic [DataWidth-1:0]            wdata_i,
  output logic                            mem_req_o,
  input  logic                            mem_gnt_i,
  output logic [AddrWidth-1:0]            mem_addr_o,
  output logic                            mem_we_o,
  output logic [DataWidth-1:0]            mem_wdata_o,
  output logic [1:0]                      mem_tid_o,
  input  logic                            rsp_valid_i,
  input  logic [1:0]                      rsp_tid_i,
  output logic [2:0]                      rsp_valid_o
);

  localparam int LoadCntW  = $clog2(MaxOutstandingLoads + 1);
  localparam int StoreCntW = $clog2(MaxOutstandingStores + 1);
  localparam logic [LoadCntW-1:0]  MaxLoads  = LoadCntW'(MaxOutstandingLoads);
  localparam logic [StoreCntW-1:0] MaxStores = StoreCntW'(MaxOutstandingStores);

  typedef enum logic {IDLE, BUSY} state_e;

  typedef struct packed {
    logic [AddrWidth-1:0] addr;
    logic                 we;
    logic [DataWidth-1:0] wdata;
    logic [1:0]           tid;
  } mem_req_t;

  state_e                state_q;
  mem_req_t              out_q;
  mem_req_t              new_req;
  logic [LoadCntW-1:0]   load_cnt_q, load_cnt_d;
  logic [StoreCntW-1:0]  store_cnt_q, store_cnt_d;
  logic                  nc_pending_q, nc_pending_d;
  logic [1:0]            rr_ptr_q, rr_ptr_d;

  logic       slot_free, load_ok;
  logic [2:0] elig, gnt;
  logic [1:0] win_idx, idx;
  logic       found, accept;
  logic       load_inc, load_dec, store_inc, store_dec;

  assign slot_free = (state_q == IDLE) || mem_gnt_i;
  assign load_ok   = load_cnt_q < MaxLoads;

  // A non-cacheable load waits until every earlier load and store has completed.
  assign elig[0] = req_i[0] && slot_free && !nc_pending_q && load_ok;
  assign elig[1] = req_i[1] && slot_free && !nc_pending_q && load_ok &&
                   (!nc_i || (load_cnt_q == '0 && store_cnt_q == '0));
  assign elig[2] = req_i[2] && slot_free && !nc_pending_q && (store_cnt_q < MaxStores);

  always_comb begin
    gnt     = 3'b000;
    win_idx = 2'd0;
    found   = 1'b0;
    idx     = rr_ptr_q;
    for (int i = 0; i < 3; i++) begin
      if (!found && elig[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        win_idx  = idx;
      end
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  assign accept = |gnt;
  assign gnt_o  = rst_ni ? gnt : 3'b000;

  always_comb begin
    new_req.addr  = addr_i[win_idx];
    new_req.we    = gnt[2];
    new_req.wdata = wdata_i;
    new_req.tid   = win_idx;
  end

  assign load_inc  = accept && !gnt[2];
  assign store_inc = accept && gnt[2];
  assign load_dec  = rsp_valid_i && !rsp_tid_i[1];
  assign store_dec = rsp_valid_i && (rsp_tid_i == 2'd2);

  always_comb begin
    load_cnt_d = load_cnt_q;
    if (load_inc && !load_dec) begin
      load_cnt_d = load_cnt_q + 1'b1;
    end else if (load_dec && !load_inc && load_cnt_q != '0) begin
      load_cnt_d = load_cnt_q - 1'b1;
    end

    store_cnt_d = store_cnt_q;
    if (store_inc && !store_dec) begin
      store_cnt_d = store_cnt_q + 1'b1;
    end else if (store_dec && !store_inc && store_cnt_q != '0) begin
      store_cnt_d = store_cnt_q - 1'b1;
    end

    nc_pending_d = nc_pending_q;
    if (gnt[1] && nc_i) begin
      nc_pending_d = 1'b1;
    end else if (rsp_valid_i && rsp_tid_i == 2'd1) begin
      nc_pending_d = 1'b0;
    end

    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      load_cnt_q   <= '0;
      store_cnt_q  <= '0;
      nc_pending_q <= 1'b0;
      rr_ptr_q     <= 2'd0;
    end else begin
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
      nc_pending_q <= nc_pending_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q <= BUSY;
            out_q   <= new_req;
          end
        end
        BUSY: begin
          if (mem_gnt_i) begin
            if (accept) begin
              out_q <= new_req;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o   = (state_q == BUSY);
  assign mem_addr_o  = out_q.addr;
  assign mem_we_o    = out_q.we;
  assign mem_wdata_o = out_q.wdata;
  assign mem_tid_o   = out_q.tid;

  assign rsp_valid_o = (rst_ni && rsp_valid_i && rsp_tid_i != 2'd3) ? (3'b001 << rsp_tid_i) : 3'b000;

  // A response for a counter already at zero means an unmatched id from the memory side.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(load_dec && !load_inc && load_cnt_q == '0));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(store_dec && !store_inc && store_cnt_q == '0));

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Directed scoreboard bench for mem_req_scheduler: grants, memory handshakes and routed responses.
module tb_mem_req_scheduler;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [2:0]       req_i;
  logic [2:0]       gnt_o;
  logic [2:0][63:0] addr_i;
  logic             nc_i;
  logic [63:0]      wdata_i;
  logic             mem_req_o;
  logic             mem_gnt_i;
  logic [63:0]      mem_addr_o;
  logic             mem_we_o;
  logic [63:0]      mem_wdata_o;
  logic [1:0]       mem_tid_o;
  logic             rsp_valid_i;
  logic [1:0]       rsp_tid_i;
  logic [2:0]       rsp_valid_o;

  mem_req_scheduler dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .addr_i      (addr_i),
    .nc_i        (nc_i),
    .wdata_i     (wdata_i),
    .mem_req_o   (mem_req_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_addr_o  (mem_addr_o),
    .mem_we_o    (mem_we_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_tid_o   (mem_tid_o),
    .rsp_valid_i (rsp_valid_i),
    .rsp_tid_i   (rsp_tid_i),
    .rsp_valid_o (rsp_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    int         cyc;
    logic [2:0] v;
  } ev_t;

  typedef struct packed {
    logic [63:0] addr;
    logic        we;
    logic [63:0] wdata;
    logic [1:0]  tid;
  } mreq_t;

  ev_t   gnt_q[$];
  ev_t   rsp_q[$];
  mreq_t mem_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_gnt(input int c, input logic [2:0] g);
    gnt_q.push_back('{cyc: c, v: g});
  endtask

  task automatic push_mem(input logic [63:0] a, input logic we, input logic [63:0] d, input logic [1:0] t);
    mem_q.push_back('{addr: a, we: we, wdata: d, tid: t});
  endtask

  task automatic rsp(input logic [1:0] t);
    rsp_valid_i = 1'b1;
    rsp_tid_i   = t;
    if (t != 2'd3) rsp_q.push_back('{cyc: cyc, v: 3'b001 << t});
    else begin
      #1;
      chk("rsp_tid3_ignored", {61'd0, rsp_valid_o}, 64'd0);
    end
    tick();
    rsp_valid_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},       {61'd0, gnt_o}, 64'd0);
    chk({tag, "_mem_req"},   {63'd0, mem_req_o}, 64'd0);
    chk({tag, "_mem_addr"},  mem_addr_o, 64'd0);
    chk({tag, "_mem_we"},    {63'd0, mem_we_o}, 64'd0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 64'd0);
    chk({tag, "_mem_tid"},   {62'd0, mem_tid_o}, 64'd0);
    chk({tag, "_rsp_valid"}, {61'd0, rsp_valid_o}, 64'd0);
  endtask

  always @(negedge clk_i) begin : mon_gnt
    ev_t e;
    if (gnt_o != 3'b000) begin
      checks++;
      if (gnt_q.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected: got gnt_o=%b at cycle %0d, none expected", gnt_o, cyc);
      end else begin
        e = gnt_q.pop_front();
        if (e.v !== gnt_o || e.cyc != cyc) begin
          errors++;
          $display("FAIL gnt: got %b at cycle %0d expected %b at cycle %0d", gnt_o, cyc, e.v, e.cyc);
        end
      end
    end
  end

  always @(negedge clk_i) begin : mon_mem
    mreq_t m;
    if (mem_req_o && mem_gnt_i) begin
      checks++;
      if (mem_q.size() == 0) begin
        errors++;
        $display("FAIL mem_unexpected: got addr %h tid %0d at cycle %0d", mem_addr_o, mem_tid_o, cyc);
      end else begin
        m = mem_q.pop_front();
        if (m.addr !== mem_addr_o || m.we !== mem_we_o || m.tid !== mem_tid_o ||
            (m.we && m.wdata !== mem_wdata_o)) begin
          errors++;
          $display("FAIL mem: got addr %h we %b wdata %h tid %0d expected addr %h we %b wdata %h tid %0d",
                   mem_addr_o, mem_we_o, mem_wdata_o, mem_tid_o, m.addr, m.we, m.wdata, m.tid);
        end
      end
    end
  end

  always @(negedge clk_i) begin : mon_rsp
    ev_t e;
    if (rsp_valid_o != 3'b000) begin
      checks++;
      if (rsp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid_o=%b at cycle %0d", rsp_valid_o, cyc);
      end else begin
        e = rsp_q.pop_front();
        if (e.v !== rsp_valid_o || e.cyc != cyc) begin
          errors++;
          $display("FAIL rsp: got %b at cycle %0d expected %b at cycle %0d", rsp_valid_o, cyc, e.v, e.cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c;
    rst_ni = 1'b0; req_i = 3'b111; nc_i = 1'b0; wdata_i = '0; addr_i = '0;
    mem_gnt_i = 1'b1; rsp_valid_i = 1'b1; rsp_tid_i = 2'd0;
    #3;
    chk_all_zero("reset");
    tick(); tick();
    rsp_valid_i = 1'b0; req_i = 3'b000; rst_ni = 1'b1;
    tick();

    // Store-credit saturation: 7 grants, then one more per ack.
    c = cyc; req_i = 3'b100;
    for (int i = 0; i < 7; i++) begin
      addr_i[2] = 64'h3000 + 64'(8 * i); wdata_i = 64'hD0 + 64'(i);
      push_gnt(c + i, 3'b100);
      push_mem(64'h3000 + 64'(8 * i), 1'b1, 64'hD0 + 64'(i), 2'd2);
      tick();
    end
    tick(); tick();
    addr_i[2] = 64'h3100; wdata_i = 64'hE0;
    rsp(2'd2);
    push_gnt(cyc, 3'b100); push_mem(64'h3100, 1'b1, 64'hE0, 2'd2);
    tick(); tick(); tick();
    req_i = 3'b000;
    for (int i = 0; i < 7; i++) rsp(2'd2);

    // Round robin 0,1,2 then port 2 alone once load credits run out.
    c = cyc; req_i = 3'b111; nc_i = 1'b0; wdata_i = 64'hF0;
    addr_i[0] = 64'h1000; addr_i[1] = 64'h2000; addr_i[2] = 64'h3000;
    push_gnt(c, 3'b001); push_mem(64'h1000, 1'b0, 64'h0, 2'd0);
    push_gnt(c + 1, 3'b010); push_mem(64'h2000, 1'b0, 64'h0, 2'd1);
    for (int i = 0; i < 7; i++) begin
      push_gnt(c + 2 + i, 3'b100); push_mem(64'h3000, 1'b1, 64'hF0, 2'd2);
    end
    for (int i = 0; i < 11; i++) tick();
    req_i = 3'b000;
    rsp(2'd0); rsp(2'd1); rsp(2'd3);
    for (int i = 0; i < 7; i++) rsp(2'd2);

    // Backpressure: request held stable, no grants while mem_gnt_i is low.
    c = cyc; mem_gnt_i = 1'b0; req_i = 3'b001; addr_i[0] = 64'h8000_0040;
    push_gnt(c, 3'b001); push_mem(64'h8000_0040, 1'b0, 64'h0, 2'd0);
    tick();
    req_i = 3'b100; addr_i[2] = 64'h4000; wdata_i = 64'h11;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_mem_req",  {63'd0, mem_req_o}, 64'd1);
      chk("bp_mem_addr", mem_addr_o, 64'h8000_0040);
      chk("bp_mem_tid",  {62'd0, mem_tid_o}, 64'd0);
      chk("bp_no_gnt",   {61'd0, gnt_o}, 64'd0);
      tick();
    end
    mem_gnt_i = 1'b1;
    push_gnt(cyc, 3'b100); push_mem(64'h4000, 1'b1, 64'h11, 2'd2);
    tick();
    req_i = 3'b000;
    tick();
    rsp(2'd0); rsp(2'd2);

    // Non-cacheable load waits for 3 store acks, then blocks everyone until its response.
    c = cyc; req_i = 3'b100; addr_i[2] = 64'h5000; wdata_i = 64'h22;
    for (int i = 0; i < 3; i++) begin
      push_gnt(c + i, 3'b100); push_mem(64'h5000, 1'b1, 64'h22, 2'd2);
    end
    tick(); tick(); tick();
    req_i = 3'b010; nc_i = 1'b1; addr_i[1] = 64'h9000_0000;
    tick(); tick();
    rsp(2'd2); rsp(2'd2); rsp(2'd2);
    push_gnt(cyc, 3'b010); push_mem(64'h9000_0000, 1'b0, 64'h0, 2'd1);
    tick();
    req_i = 3'b101; nc_i = 1'b0; addr_i[0] = 64'h6000; addr_i[2] = 64'h5100; wdata_i = 64'h33;
    tick(); tick(); tick();
    rsp(2'd1);
    push_gnt(cyc, 3'b100);     push_mem(64'h5100, 1'b1, 64'h33, 2'd2);
    push_gnt(cyc + 1, 3'b001); push_mem(64'h6000, 1'b0, 64'h0, 2'd0);
    tick(); tick();
    req_i = 3'b000;
    rsp(2'd0); rsp(2'd2);

    // Accept and tid 0 response together at load_cnt=1: count stays at 1.
    req_i = 3'b001; addr_i[0] = 64'h7000;
    push_gnt(cyc, 3'b001); push_mem(64'h7000, 1'b0, 64'h0, 2'd0);
    tick();
    push_gnt(cyc, 3'b001); push_mem(64'h7000, 1'b0, 64'h0, 2'd0);
    rsp(2'd0);
    push_gnt(cyc, 3'b001); push_mem(64'h7000, 1'b0, 64'h0, 2'd0);
    tick(); tick();
    req_i = 3'b000;
    rsp(2'd0); rsp(2'd0);

    // Reset while BUSY with store_cnt=4 discards credits.
    c = cyc; req_i = 3'b100;
    for (int i = 0; i < 4; i++) begin
      addr_i[2] = 64'hA000 + 64'(8 * i); wdata_i = 64'hA0 + 64'(i);
      push_gnt(c + i, 3'b100);
      if (i < 3) push_mem(64'hA000 + 64'(8 * i), 1'b1, 64'hA0 + 64'(i), 2'd2);
      tick();
    end
    req_i = 3'b000; mem_gnt_i = 1'b0;
    tick();
    req_i = 3'b100;
    #1;
    chk("pre_rst_mem_req",  {63'd0, mem_req_o}, 64'd1);
    chk("pre_rst_mem_addr", mem_addr_o, 64'hA018);
    #1;
    rst_ni = 1'b0; rsp_valid_i = 1'b1; rsp_tid_i = 2'd2;
    #1;
    chk_all_zero("midrst");
    rsp_valid_i = 1'b0; mem_gnt_i = 1'b1; addr_i[2] = 64'hB000; wdata_i = 64'hB0;
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 7; i++) begin
      push_gnt(cyc + i, 3'b100); push_mem(64'hB000, 1'b1, 64'hB0, 2'd2);
    end
    for (int i = 0; i < 9; i++) tick();
    req_i = 3'b000;
    tick(); tick();

    chk("gnt_queue_left", 64'(gnt_q.size()), 64'd0);
    chk("mem_queue_left", 64'(mem_q.size()), 64'd0);
    chk("rsp_queue_left", 64'(rsp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_scheduler.md
# mem_req_scheduler

Arbitrates the instruction-cache refill, data-cache load-miss and write-through store-buffer requesters onto the single memory request channel of the write-through cache subsystem. It enforces the outstanding-load and outstanding-store limits and serializes non-cacheable loads against stores for non-idempotent regions. It also routes memory responses back to the issuing requester. It sits between the cache miss logic and the NoC adapter.

## Interface
- `AddrWidth`, default 64: memory address width.
- `DataWidth`, default 64: store data width.
- `MaxOutstandingLoads`, default 2: load credit limit, shared by ports 0 and 1.
- `MaxOutstandingStores`, default 7: store credit limit for port 2.

Ports:
- `clk_i`  in  1: clock.
- `rst_ni`  in  1: asynchronous, active-low reset.
- `req_i`  in  3: request per port. Port 0 is I$ refill, port 1 is D$ load, port 2 is D$ store.
- `gnt_o`  out  3: one-hot grant. A request is accepted in the cycle that `req_i[k] && gnt_o[k]`.
- `addr_i`  in  3×AddrWidth: per-port address.
- `nc_i`  in  1: port 1 load is non-cacheable / non-idempotent.
- `wdata_i`  in  DataWidth: port 2 store data.
- `mem_req_o`  out  1: memory request valid.
- `mem_gnt_i`  in  1: memory accepts the request.
- `mem_addr_o`  out  AddrWidth: request address.
- `mem_we_o`  out  1: request is a store.
- `mem_wdata_o`  out  DataWidth: store data.
- `mem_tid_o`  out  2: transaction id, equal to the issuing port index.
- `rsp_valid_i`  in  1: memory response or store ack.
- `rsp_tid_i`  in  2: id of the response.
- `rsp_valid_o`  out  3: response routed one-hot to `rsp_tid_i`.

## Operation
- Counters:
  - `load_cnt` is `$clog2(MaxOutstandingLoads+1)` bits. It increments on acceptance by port 0 or 1 and decrements on a response with tid 0 or 1.
  - `store_cnt` is sized the same way from `MaxOutstandingStores`. It increments on acceptance by port 2 and decrements on a response with tid 2.
  - Credit is reserved at acceptance, not at `mem_gnt_i`.
  - When an increment and a decrement hit the same counter in one cycle, the counter does not change.
- `nc_pending` flag:
  - Set on acceptance of a port 1 request with `nc_i=1`.
  - Cleared on the next response with tid 1.
- Eligibility of port k, evaluated on current register values:
  - Port k must be requesting and the output slot must be free: state IDLE, or state BUSY with `mem_gnt_i=1`.
  - No port is eligible while `nc_pending` is set.
  - Ports 0 and 1 additionally need `load_cnt < MaxOutstandingLoads`.
  - Port 1 with `nc_i=1` additionally needs `load_cnt==0` and `store_cnt==0`.
  - Port 2 additionally needs `store_cnt < MaxOutstandingStores`.
- Arbitration:
  - Round-robin among eligible ports, with priority starting at `rr_ptr`.
  - On acceptance, `rr_ptr` becomes winner+1 mod 3.
  - At most one `gnt_o` bit is high.
- State machine:
  - IDLE: on acceptance, latch addr, we, wdata and tid into the output registers and go to BUSY.
  - BUSY: `mem_req_o=1` and the output registers are held stable.
  - BUSY with `mem_gnt_i=1` and a new acceptance in the same cycle: reload the registers and stay in BUSY.
  - BUSY with `mem_gnt_i=1` and no new acceptance: go to IDLE.
- Responses:
  - `rsp_valid_o = rsp_valid_i ? (1 << rsp_tid_i) : 0`.
  - Tid 3 is ignored.
  - A response that would decrement a counter already at zero leaves the counter at zero and raises a simulation assertion.

## Timing
- Reset values:
  - `gnt_o=0`, `mem_req_o=0`, `mem_addr_o=0`, `mem_we_o=0`, `mem_wdata_o=0`, `mem_tid_o=0`, `rsp_valid_o=0`.
  - Counters are 0, `nc_pending=0`, `rr_ptr=0`, state is IDLE.
- `gnt_o` is combinational, in the same cycle as `req_i`.
- `mem_req_o` rises the cycle after acceptance.
- Sustained throughput is one request per cycle when `mem_gnt_i` stays high.
- `rsp_valid_o` is combinational, with zero latency.
- Counter and flag updates from a response are visible to eligibility in the next cycle.
- Reset asserted mid-transaction drops `mem_req_o` immediately and discards all credits.

## Test plan
- Store-credit saturation:
  - Stimulus: port 2 requests continuously, `mem_gnt_i=1`, no responses.
  - Required response: exactly 7 grants, then `gnt_o[2]=0`.
  - One ack with tid 2 must produce exactly one more grant, on the following cycle.
- Round-robin fairness:
  - Stimulus: all three ports request continuously with ample credits and `mem_gnt_i=1`.
  - Required response: grant order 0, 1, 2, 0, … while load credits last. Port 2 continues once the load credits are exhausted.
- Backpressure:
  - Stimulus: `mem_gnt_i=0` for 5 cycles after an accept with addr 0x8000_0040.
  - Required response: `mem_req_o`, `mem_addr_o` and `mem_tid_o` stay stable and no new `gnt_o` is given.
  - When `mem_gnt_i=1`, a pending request is granted in the same cycle.
- Non-cacheable ordering:
  - Stimulus: `store_cnt=3` and a port 1 request with `nc_i=1`.
  - Required response: no `gnt_o[1]` until three tid 2 acks have arrived. Then it is granted.
  - While `nc_pending` is set, port 0 and port 2 requests stay ungranted until the tid 1 response.
- Simultaneous events:
  - Stimulus: an accept on port 0 coincides with a tid 0 response at `load_cnt=1`.
  - Required response: `load_cnt` stays 1, and `rsp_valid_o=3'b001`.
- Reset mid-operation:
  - Stimulus: assert `rst_ni` low while in BUSY with `store_cnt=4`.
  - Required response: all outputs are 0 in the same cycle. After release, 7 store grants are available.
